// File: rtl/reg_load_pkg.sv
// Shared types and defaults for the register-bank load controller.
package reg_load_pkg;

  // Controller states: idle, debounce press, strobe, held, debounce release.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PULSE    = 3'd2,
    HELD     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset (clears both stages)
//   async_in - raw asynchronous input
//   sync_out - input after two flop stages
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/reg_load_ctrl.sv
// Load controller for a 4-bit enabled D-register bank: synchronizes a bouncy
// pushbutton and slide switches, debounces the button, and issues exactly one
// single-cycle enable per accepted press with the captured switch value.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-low reset
//   btn_load - raw asynchronous load pushbutton, active-high
//   sw       - raw asynchronous switch value
//   d_out    - captured switch value (register bank D), registered
//   en_out   - one-cycle load strobe (register bank en), registered
//   load_cnt - count of accepted presses, wraps at 256, registered
module reg_load_ctrl
  import reg_load_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic [7:0]       load_cnt
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic [WIDTH-1:0] sw_s;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] d_nx;
  logic             en_nx;
  logic [7:0]       load_cnt_nx;

  sync_2ff #(.WIDTH(1)) u_sync_btn (
    .clk      (clk),
    .rst      (rst),
    .async_in (btn_load),
    .sync_out (btn_s)
  );

  sync_2ff #(.WIDTH(WIDTH)) u_sync_sw (
    .clk      (clk),
    .rst      (rst),
    .async_in (sw),
    .sync_out (sw_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      d_out    <= '0;
      en_out   <= 1'b0;
      load_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      d_out    <= d_nx;
      en_out   <= en_nx;
      load_cnt <= load_cnt_nx;
    end
  end

  // Next state; the counter restarts from zero on every state change.
  always_comb begin
    state_nx    = IDLE;
    cnt_nx      = '0;
    d_nx        = d_out;
    load_cnt_nx = load_cnt;

    case (state)
      IDLE: begin
        if (btn_s) state_nx = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          // Capture and count together so both are valid alongside en_out.
          state_nx    = PULSE;
          d_nx        = sw_s;
          load_cnt_nx = load_cnt + 8'd1;
        end else begin
          state_nx = DB_PRESS;
          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      PULSE: begin
        state_nx = HELD;
      end
      HELD: begin
        state_nx = btn_s ? HELD : DB_REL;
      end
      DB_REL: begin
        if (btn_s) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          state_nx = DB_REL;
          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Registered Moore decode: high for exactly the PULSE cycle.
    en_nx = (state_nx == PULSE);
  end

endmodule
